// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with registered flags, sticky errors and synchronous flush.
// Optional occupancy high-water mark is compiled in with `define FIFO_PEAK_STATS_EN.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          write_enable,
    input  logic                          read_enable,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          clear_errors,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          data_valid,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          underflow
`ifdef FIFO_PEAK_STATS_EN
    ,
    output logic [$clog2(FIFO_DEPTH):0]   peak_count
`endif
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  new_overflow;
    logic                  new_underflow;
    logic [CNT_W-1:0]      count_next;

    // Acceptance uses the registered flags, i.e. the state before the edge.
    assign rd_acc        = read_enable & ~fifo_empty;
    assign wr_acc        = write_enable & (~fifo_full | rd_acc);
    assign new_overflow  = ~flush & write_enable & fifo_full & ~rd_acc;
    assign new_underflow = ~flush & read_enable & fifo_empty;

    always_comb begin
        // NOTE: default assigned first so no path leaves count_next unassigned (no latch).
        count_next = fifo_count;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = fifo_count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        end
    end

    // NOTE: storage has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc && !flush) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            fifo_full    <= 1'b0;
            fifo_empty   <= 1'b1;
            almost_full  <= ('0 >= AF_C);
            almost_empty <= 1'b1;
            data_out     <= '0;
            data_valid   <= 1'b0;
        end else begin
            fifo_count   <= count_next;
            fifo_full    <= (count_next == DEPTH_C);
            fifo_empty   <= (count_next == '0);
            almost_full  <= (count_next >= AF_C);
            almost_empty <= (count_next <= AE_C);
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                data_valid <= 1'b0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                end
                if (rd_acc) begin
                    rd_ptr   <= rd_ptr + ADDR_W'(1);
                    data_out <= mem[rd_ptr];
                end
                data_valid <= rd_acc;
            end
        end
    end

    // A fresh error in the same cycle as clear_errors wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= new_overflow  | (overflow  & ~clear_errors);
            underflow <= new_underflow | (underflow & ~clear_errors);
        end
    end

`ifdef FIFO_PEAK_STATS_EN
    logic [CNT_W-1:0] peak_base;

    assign peak_base = clear_errors ? '0 : peak_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_count <= '0;
        end else begin
            peak_count <= (count_next > peak_base) ? count_next : peak_base;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: queue-based reference model plus directed literal checks.
// Define FIFO_PEAK_STATS_EN for both files to exercise the peak_count feature.
module tb_sync_fifo_param;

    localparam int DW  = 8;
    localparam int DEP = 16;
    localparam int AF  = 14;
    localparam int AE  = 2;
    localparam int CW  = $clog2(DEP) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          write_enable = 1'b0;
    logic          read_enable = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          clear_errors = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          fifo_full;
    logic          fifo_empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          underflow;
`ifdef FIFO_PEAK_STATS_EN
    logic [CW-1:0] peak_count;
`endif

    sync_fifo_param #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEP), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .write_enable(write_enable), .read_enable(read_enable),
        .data_in(data_in), .clear_errors(clear_errors),
        .data_out(data_out), .data_valid(data_valid),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .fifo_count(fifo_count), .overflow(overflow), .underflow(underflow)
`ifdef FIFO_PEAK_STATS_EN
        , .peak_count(peak_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, outputs derived from its size.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout  = '0;
    logic          m_valid = 1'b0;
    logic          m_ovf   = 1'b0;
    logic          m_udf   = 1'b0;
    int            m_peak  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_peak = 0;
        end else begin
            bit was_full, was_empty, rd, wr;
            was_full  = (q.size() == DEP);
            was_empty = (q.size() == 0);
            rd = read_enable && !was_empty;
            wr = write_enable && (!was_full || rd);
            if (clear_errors) begin
                m_ovf = 1'b0; m_udf = 1'b0; m_peak = 0;
            end
            if (!flush && write_enable && was_full && !rd) m_ovf = 1'b1;
            if (!flush && read_enable && was_empty)        m_udf = 1'b1;
            if (flush) begin
                q.delete();
                m_valid = 1'b0;
            end else begin
                m_valid = rd;
                if (rd) m_dout = q.pop_front();
                if (wr) q.push_back(data_in);
            end
            if (q.size() > m_peak) m_peak = q.size();
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("count", 32'(fifo_count), 32'(q.size()));
            check("full", 32'(fifo_full), 32'(q.size() == DEP));
            check("empty", 32'(fifo_empty), 32'(q.size() == 0));
            check("almost_full", 32'(almost_full), 32'(q.size() >= AF));
            check("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
            check("data_valid", 32'(data_valid), 32'(m_valid));
            check("data_out", 32'(data_out), 32'(m_dout));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("underflow", 32'(underflow), 32'(m_udf));
`ifdef FIFO_PEAK_STATS_EN
            check("peak_count", 32'(peak_count), 32'(m_peak));
`endif
        end
    end

    // One clock of stimulus: inputs applied at negedge, cleared just after the posedge.
    task automatic step(input logic we, input logic re, input logic [DW-1:0] din,
                        input logic fl, input logic ce);
        @(negedge clk);
        write_enable = we; read_enable = re; data_in = din; flush = fl; clear_errors = ce;
        @(posedge clk);
        #1;
        write_enable = 1'b0; read_enable = 1'b0; flush = 1'b0; clear_errors = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_almost_empty", 32'(almost_empty), 32'd1);
        check("rst_almost_full", 32'(almost_full), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fill 0x00..0x0F with threshold edges checked literally.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, DW'(i), 1'b0, 1'b0);
            if (i == 1)  check("ae_at_2", 32'(almost_empty), 32'd1);
            if (i == 2)  check("ae_at_3", 32'(almost_empty), 32'd0);
            if (i == 12) check("af_at_13", 32'(almost_full), 32'd0);
            if (i == 13) check("af_at_14", 32'(almost_full), 32'd1);
        end
        check("fill_count", 32'(fifo_count), 32'd16);
        check("fill_full", 32'(fifo_full), 32'd1);
        step(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(fifo_count), 32'd16);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Full: simultaneous write 0xAA and read.
        step(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
        check("fwr_dout", 32'(data_out), 32'h00);
        check("fwr_count", 32'(fifo_count), 32'd16);
        check("fwr_ovf", 32'(overflow), 32'd0);

        // Drain: 0x01..0x0F then 0xAA.
        for (int i = 1; i < 17; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            check("drain_valid", 32'(data_valid), 32'd1);
            check("drain_dout", 32'(data_out), (i == 16) ? 32'hAA : 32'(i));
        end
        check("drain_empty", 32'(fifo_empty), 32'd1);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("udf_set", 32'(underflow), 32'd1);
        check("udf_valid", 32'(data_valid), 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Empty: simultaneous write 0x55 and read.
        step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        check("ewr_udf", 32'(underflow), 32'd1);
        check("ewr_count", 32'(fifo_count), 32'd1);
        check("ewr_valid", 32'(data_valid), 32'd0);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("ewr_dout", 32'(data_out), 32'h55);

        // Clear with a new error in the same cycle: the new error wins.
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        check("clr_vs_new", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // 40 interleaved cycles forcing pointer wrap.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, (i % 3) != 0, DW'(8'h30 + i), 1'b0, 1'b0);
        end
        while (fifo_count != 0) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("wrap_last", 32'(data_out), 32'h30 + 32'd39);

        // Flush with a concurrent write at count 5.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
        check("flush_count", 32'(fifo_count), 32'd0);
        check("flush_empty", 32'(fifo_empty), 32'd1);
        step(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("post_flush_dout", 32'(data_out), 32'h77);

        // Asynchronous reset mid-burst.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, DW'(i), 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("mrst_count", 32'(fifo_count), 32'd0);
        check("mrst_empty", 32'(fifo_empty), 32'd1);
        check("mrst_dout", 32'(data_out), 32'd0);
        check("mrst_ae", 32'(almost_empty), 32'd1);
        @(negedge clk);
        rst = 1'b0;

`ifdef FIFO_PEAK_STATS_EN
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, DW'(i), 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("peak_9", 32'(peak_count), 32'd9);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("peak_clr", 32'(peak_count), 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
